mem_copier: RTL and testbench

- Bus initiator that drives the memory-container port (addr, din, wen) to move blocks of words without CPU involvement.
- Two modes:
  - copy: read src[i], write dst[i].
  - fill: write a constant pattern to dst[i].
- Sits beside the CPU on the memory bus behind an external arbiter (req/gnt); chip selects are produced by the existing address decoder from the address it drives.

---
 rtl/mem_copier_pkg.sv | 15 +
 rtl/mem_copier.sv | 168 ++++++++++++++++
 tb/tb_mem_copier.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_copier_pkg.sv
// Shared definitions for the memory block copier: FSM encoding and transfer modes.
package mem_copier_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRd,
        StWr,
        StFin
    } state_e;

    localparam logic ModeCopy = 1'b0;
    localparam logic ModeFill = 1'b1;

endpackage

// File: rtl/mem_copier.sv
// Memory-bus initiator that copies a block of words (src -> dst) or fills a
// block with a constant pattern. Copy alternates read/write cycles; fill issues
// one write per cycle. Bus ownership is requested through an external arbiter.
module mem_copier
    import mem_copier_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wen,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   pattern_q, pattern_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bus_req_q, bus_req_d;
    logic               mem_wen_q, mem_wen_d;
    logic [31:0]        mem_addr_q, mem_addr_d;

    // Next-state and transfer bookkeeping.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        count_d   = count_q;
        pattern_d = pattern_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len != '0) begin
                        mode_d    = mode;
                        src_d     = src;
                        dst_d     = dst;
                        count_d   = len;
                        pattern_d = pattern;
                        state_d   = StReq;
                    end else begin
                        // Empty transfer: complete without touching the bus.
                        state_d = StFin;
                    end
                end
            end
            StReq: begin
                if (bus_gnt) begin
                    state_d = (mode_q == ModeFill) ? StWr : StRd;
                end
            end
            StRd: begin
                state_d = StWr;
            end
            StWr: begin
                src_d   = src_q + 32'd1;
                dst_d   = dst_q + 32'd1;
                count_d = count_q - LEN_W'(1);
                if (count_q == LEN_W'(1)) begin
                    state_d = StFin;
                end else begin
                    state_d = (mode_q == ModeFill) ? StWr : StRd;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        bus_req_d  = 1'b0;
        mem_wen_d  = 1'b0;
        mem_addr_d = '0;
        case (state_d)
            StReq: begin
                busy_d    = 1'b1;
                bus_req_d = 1'b1;
            end
            StRd: begin
                busy_d     = 1'b1;
                bus_req_d  = 1'b1;
                mem_addr_d = src_d;
            end
            StWr: begin
                busy_d     = 1'b1;
                bus_req_d  = 1'b1;
                mem_wen_d  = 1'b1;
                mem_addr_d = dst_d;
            end
            StFin: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Write data: read data arrives during the write cycle, so copy passes it through.
    always_comb begin
        mem_wdata = '0;
        if (state_q == StWr) begin
            mem_wdata = (mode_q == ModeFill) ? pattern_q : mem_rdata;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= ModeCopy;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_req_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_req_q  <= bus_req_d;
            mem_wen_q  <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bus_req  = bus_req_q;
    assign mem_wen  = mem_wen_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_mem_copier.sv
// Directed self-checking bench for mem_copier.
module tb_mem_copier;

    localparam logic [31:0] Key = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] pattern;
    logic        busy;
    logic        done;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_copier #(
        .WIDTH(32),
        .LEN_W(16)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wen  (mem_wen),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read, word at address A holds A ^ Key.
    always @(posedge clk) mem_rdata <= mem_addr ^ Key;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ebusy, input logic edone,
                             input logic ereq, input logic ewen, input logic [31:0] eaddr,
                             input logic [31:0] edata);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, edone});
        chk({tag, ".req"}, {31'd0, bus_req}, {31'd0, ereq});
        chk({tag, ".wen"}, {31'd0, mem_wen}, {31'd0, ewen});
        chk({tag, ".addr"}, mem_addr, eaddr);
        chk({tag, ".wdata"}, mem_wdata, edata);
    endtask

    // Pulse start for one cycle; returns in the cycle after the sampling edge.
    task automatic launch(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [31:0] p);
        mode    = m;
        src     = s;
        dst     = d;
        len     = l;
        pattern = p;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        src     = '0;
        dst     = '0;
        len     = '0;
        pattern = '0;
        bus_gnt = 1'b1;
        step();
        step();
        chk_state("reset", 0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        step();

        // Copy 4 words: REQ, then RD/WR pairs, done on the 10th edge after start.
        launch(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
        chk_state("copy_req", 1, 0, 1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_state("copy_rd", 1, 0, 1, 0, 32'h100 + i, 32'h0);
            step();
            chk_state("copy_wr", 1, 0, 1, 1, 32'h200 + i, (32'h100 + i) ^ Key);
        end
        step();
        chk_state("copy_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();
        chk_state("copy_idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Fill 3 words: back-to-back writes, no reads.
        launch(1'b1, 32'h0, 32'h10, 16'd3, 32'hDEAD_BEEF);
        chk_state("fill_req", 1, 0, 1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("fill_wr", 1, 0, 1, 1, 32'h10 + i, 32'hDEAD_BEEF);
        end
        step();
        chk_state("fill_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();
        chk_state("fill_idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Zero-length transfer: immediate done, no bus activity.
        launch(1'b0, 32'h40, 32'h50, 16'd0, 32'h0);
        chk_state("len0_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();
        chk_state("len0_idle", 0, 0, 0, 0, 32'h0, 32'h0);

        // Grant delayed 5 cycles; a stray start during busy must be ignored.
        bus_gnt = 1'b0;
        launch(1'b0, 32'h300, 32'h400, 16'd2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk_state("gnt_wait", 1, 0, 1, 0, 32'h0, 32'h0);
            if (i == 2) begin
                launch(1'b1, 32'h800, 32'h900, 16'd5, 32'h1111_1111);
            end else begin
                step();
            end
        end
        chk_state("gnt_wait_last", 1, 0, 1, 0, 32'h0, 32'h0);
        bus_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_state("gnt_rd", 1, 0, 1, 0, 32'h300 + i, 32'h0);
            step();
            chk_state("gnt_wr", 1, 0, 1, 1, 32'h400 + i, (32'h300 + i) ^ Key);
        end
        step();
        chk_state("gnt_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();

        // Address wrap during fill.
        launch(1'b1, 32'h0, 32'hFFFF_FFFE, 16'd3, 32'h1234_5678);
        chk_state("wrap_req", 1, 0, 1, 0, 32'h0, 32'h0);
        step();
        chk_state("wrap_wr0", 1, 0, 1, 1, 32'hFFFF_FFFE, 32'h1234_5678);
        step();
        chk_state("wrap_wr1", 1, 0, 1, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        step();
        chk_state("wrap_wr2", 1, 0, 1, 1, 32'h0000_0000, 32'h1234_5678);
        step();
        chk_state("wrap_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();

        // Reset mid-copy after 3 words, with a start in the same cycle (reset wins).
        launch(1'b0, 32'h500, 32'h600, 16'd8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("mid_rd", 1, 0, 1, 0, 32'h500 + i, 32'h0);
            step();
            chk_state("mid_wr", 1, 0, 1, 1, 32'h600 + i, (32'h500 + i) ^ Key);
        end
        step();
        chk_state("mid_rd3", 1, 0, 1, 0, 32'h503, 32'h0);
        reset = 1'b1;
        launch(1'b1, 32'h0, 32'hA00, 16'd2, 32'h5555_5555);
        chk_state("mid_abort", 0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("mid_quiet", 0, 0, 0, 0, 32'h0, 32'h0);
        end

        // Fresh copy after abort runs from the new inputs.
        launch(1'b0, 32'h20, 32'h30, 16'd1, 32'h0);
        chk_state("post_req", 1, 0, 1, 0, 32'h0, 32'h0);
        step();
        chk_state("post_rd", 1, 0, 1, 0, 32'h20, 32'h0);
        step();
        chk_state("post_wr", 1, 0, 1, 1, 32'h30, 32'h20 ^ Key);
        step();
        chk_state("post_fin", 0, 1, 0, 0, 32'h0, 32'h0);
        step();
        chk_state("post_idle", 0, 0, 0, 0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
